// File: rtl/exec_stage_cond.sv
`default_nettype none
// ============================================================================
//  Module      : exec_stage_cond
//  Description : Execute stage of the pipelined ARM core. Holds the D->E
//                pipeline register (controls, condition, destination and
//                operands) with stall and flush. Computes the ALU result and
//                checks the ARM condition field against the architectural
//                NZCV flag register, which is also updated here.
//  Ports       : clk, reset (sync, active-low)
//                StallE / FlushE                 - hold / bubble E register
//                PCSrcD..ALUSrcD, FlagWriteD,
//                ALUControlD, CondD, RdD,
//                RD1D, RD2D, ExtImmD             - decode-stage inputs
//                PCSrcE, RegWriteE, MemWriteE    - controls gated by CondExE
//                MemtoRegE, CondExE, RdE,
//                ALUResultE, WriteDataE, FlagsE  - execute-stage outputs
//  Revision    : 1.0 - initial release
// ============================================================================
module exec_stage_cond #(
    parameter int WIDTH = 32,
    parameter int RADDR = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             StallE,
    input  logic             FlushE,
    input  logic             PCSrcD,
    input  logic             RegWriteD,
    input  logic             MemtoRegD,
    input  logic             MemWriteD,
    input  logic             ALUSrcD,
    input  logic [1:0]       FlagWriteD,
    input  logic [2:0]       ALUControlD,
    input  logic [3:0]       CondD,
    input  logic [RADDR-1:0] RdD,
    input  logic [WIDTH-1:0] RD1D,
    input  logic [WIDTH-1:0] RD2D,
    input  logic [WIDTH-1:0] ExtImmD,
    output logic             PCSrcE,
    output logic             RegWriteE,
    output logic             MemWriteE,
    output logic             MemtoRegE,
    output logic             CondExE,
    output logic [RADDR-1:0] RdE,
    output logic [WIDTH-1:0] ALUResultE,
    output logic [WIDTH-1:0] WriteDataE,
    output logic [3:0]       FlagsE
);

    localparam logic [3:0] c_COND_AL = 4'hE;

    localparam logic [2:0] c_ALU_ADD = 3'b000;
    localparam logic [2:0] c_ALU_SUB = 3'b001;
    localparam logic [2:0] c_ALU_AND = 3'b010;
    localparam logic [2:0] c_ALU_ORR = 3'b011;
    localparam logic [2:0] c_ALU_EOR = 3'b100;
    localparam logic [2:0] c_ALU_MOV = 3'b101;
    localparam logic [2:0] c_ALU_BIC = 3'b110;
    localparam logic [2:0] c_ALU_MVN = 3'b111;

    // ------------------------------------------------------------------
    // E pipeline register
    // ------------------------------------------------------------------
    logic             r_pcsrc;
    logic             r_regwrite;
    logic             r_memtoreg;
    logic             r_memwrite;
    logic             r_alusrc;
    logic [1:0]       r_flagwrite;
    logic [2:0]       r_alucontrol;
    logic [3:0]       r_cond;
    logic [RADDR-1:0] r_rd;
    logic [WIDTH-1:0] r_rd1;
    logic [WIDTH-1:0] r_rd2;
    logic [WIDTH-1:0] r_extimm;
    logic [3:0]       r_flags;   // {N,Z,C,V}

    // A bubble is an always-executed no-op: every control is 0, so it can
    // neither write state nor assert a gated output even though AL passes.
    always_ff @(posedge clk) begin
        if (!reset || FlushE) begin
            r_pcsrc      <= 1'b0;
            r_regwrite   <= 1'b0;
            r_memtoreg   <= 1'b0;
            r_memwrite   <= 1'b0;
            r_alusrc     <= 1'b0;
            r_flagwrite  <= 2'b00;
            r_alucontrol <= 3'b000;
            r_cond       <= c_COND_AL;
            r_rd         <= '0;
            r_rd1        <= '0;
            r_rd2        <= '0;
            r_extimm     <= '0;
        end else if (!StallE) begin
            r_pcsrc      <= PCSrcD;
            r_regwrite   <= RegWriteD;
            r_memtoreg   <= MemtoRegD;
            r_memwrite   <= MemWriteD;
            r_alusrc     <= ALUSrcD;
            r_flagwrite  <= FlagWriteD;
            r_alucontrol <= ALUControlD;
            r_cond       <= CondD;
            r_rd         <= RdD;
            r_rd1        <= RD1D;
            r_rd2        <= RD2D;
            r_extimm     <= ExtImmD;
        end
    end

    // ------------------------------------------------------------------
    // ALU
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] w_srcb;
    logic             w_sub;
    logic [WIDTH-1:0] w_addb;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_result;
    logic             w_n;
    logic             w_z;
    logic             w_c;
    logic             w_v;

    assign w_srcb = r_alusrc ? r_extimm : r_rd2;
    assign w_sub  = (r_alucontrol == c_ALU_SUB);
    // Subtraction shares the adder as A + ~B + 1, so carry-out is the
    // ARM "no borrow" flag directly.
    assign w_addb = w_sub ? ~w_srcb : w_srcb;
    assign w_sum  = {1'b0, r_rd1} + {1'b0, w_addb} + {{WIDTH{1'b0}}, w_sub};

    always_comb begin
        w_result = '0;
        w_c      = 1'b0;
        w_v      = 1'b0;
        case (r_alucontrol)
            c_ALU_ADD, c_ALU_SUB: begin
                w_result = w_sum[WIDTH-1:0];
                w_c      = w_sum[WIDTH];
                // Overflow: both addends share a sign the result lacks.
                w_v      = (r_rd1[WIDTH-1] == w_addb[WIDTH-1]) &&
                           (w_sum[WIDTH-1] != r_rd1[WIDTH-1]);
            end
            c_ALU_AND: w_result = r_rd1 & w_srcb;
            c_ALU_ORR: w_result = r_rd1 | w_srcb;
            c_ALU_EOR: w_result = r_rd1 ^ w_srcb;
            c_ALU_MOV: w_result = w_srcb;
            c_ALU_BIC: w_result = r_rd1 & ~w_srcb;
            c_ALU_MVN: w_result = ~w_srcb;
            default:   w_result = '0;
        endcase
    end

    assign w_n = w_result[WIDTH-1];
    assign w_z = (w_result == '0);

    // ------------------------------------------------------------------
    // Condition check against the architectural flags
    // ------------------------------------------------------------------
    logic w_fn;
    logic w_fz;
    logic w_fc;
    logic w_fv;
    logic w_condex;

    assign {w_fn, w_fz, w_fc, w_fv} = r_flags;

    always_comb begin
        w_condex = 1'b0;
        case (r_cond)
            4'h0: w_condex = w_fz;
            4'h1: w_condex = !w_fz;
            4'h2: w_condex = w_fc;
            4'h3: w_condex = !w_fc;
            4'h4: w_condex = w_fn;
            4'h5: w_condex = !w_fn;
            4'h6: w_condex = w_fv;
            4'h7: w_condex = !w_fv;
            4'h8: w_condex = w_fc && !w_fz;
            4'h9: w_condex = !w_fc || w_fz;
            4'hA: w_condex = (w_fn == w_fv);
            4'hB: w_condex = (w_fn != w_fv);
            4'hC: w_condex = !w_fz && (w_fn == w_fv);
            4'hD: w_condex = w_fz || (w_fn != w_fv);
            4'hE: w_condex = 1'b1;
            default: w_condex = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Flag register: written on the edge the instruction leaves E, which
    // includes a flush edge (the instruction retires ahead of the bubble)
    // but never a stalled edge.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_flags <= 4'b0000;
        end else if (!StallE && w_condex) begin
            if (r_flagwrite[1]) begin
                r_flags[3:2] <= {w_n, w_z};
            end
            if (r_flagwrite[0]) begin
                r_flags[1:0] <= {w_c, w_v};
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign CondExE    = w_condex;
    assign PCSrcE     = r_pcsrc    & w_condex;
    assign RegWriteE  = r_regwrite & w_condex;
    assign MemWriteE  = r_memwrite & w_condex;
    assign MemtoRegE  = r_memtoreg;
    assign RdE        = r_rd;
    assign ALUResultE = w_result;
    assign WriteDataE = r_rd2;
    assign FlagsE     = r_flags;

endmodule
`default_nettype wire

// File: tb/tb_exec_stage_cond.sv
`default_nettype none
// ============================================================================
//  Module      : tb_exec_stage_cond
//  Description : Self-checking bench for exec_stage_cond. A stimulus process
//                drives one decode-stage instruction per cycle and pushes the
//                reference model's expected E outputs into a queue; a monitor
//                pops and compares after every rising edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_exec_stage_cond;

    typedef struct packed {
        logic        pcsrc;
        logic        regwrite;
        logic        memtoreg;
        logic        memwrite;
        logic        alusrc;
        logic [1:0]  fw;
        logic [2:0]  aluc;
        logic [3:0]  cond;
        logic [3:0]  rd;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] ext;
    } instr_t;

    typedef struct packed {
        logic   rst_n;
        logic   stall;
        logic   flush;
        instr_t d;
    } stim_t;

    typedef struct packed {
        logic        pcsrc;
        logic        regwrite;
        logic        memwrite;
        logic        memtoreg;
        logic        condex;
        logic [3:0]  rd;
        logic [31:0] res;
        logic [31:0] wd;
        logic [3:0]  flags;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    stim_t cur = '0;

    logic        PCSrcE, RegWriteE, MemWriteE, MemtoRegE, CondExE;
    logic [3:0]  RdE;
    logic [31:0] ALUResultE, WriteDataE;
    logic [3:0]  FlagsE;

    exec_stage_cond #(.WIDTH(32), .RADDR(4)) dut (
        .clk         (clk),
        .reset       (cur.rst_n),
        .StallE      (cur.stall),
        .FlushE      (cur.flush),
        .PCSrcD      (cur.d.pcsrc),
        .RegWriteD   (cur.d.regwrite),
        .MemtoRegD   (cur.d.memtoreg),
        .MemWriteD   (cur.d.memwrite),
        .ALUSrcD     (cur.d.alusrc),
        .FlagWriteD  (cur.d.fw),
        .ALUControlD (cur.d.aluc),
        .CondD       (cur.d.cond),
        .RdD         (cur.d.rd),
        .RD1D        (cur.d.rd1),
        .RD2D        (cur.d.rd2),
        .ExtImmD     (cur.d.ext),
        .PCSrcE      (PCSrcE),
        .RegWriteE   (RegWriteE),
        .MemWriteE   (MemWriteE),
        .MemtoRegE   (MemtoRegE),
        .CondExE     (CondExE),
        .RdE         (RdE),
        .ALUResultE  (ALUResultE),
        .WriteDataE  (WriteDataE),
        .FlagsE      (FlagsE)
    );

    // ------------------------------------------------------------------
    // Reference model: instruction sitting in E plus the flag register
    // ------------------------------------------------------------------
    instr_t m_e;
    logic [3:0] m_flags;
    exp_t sb_q[$];
    int n_checks = 0;
    int n_errors = 0;

    function automatic instr_t bubble();
        instr_t b;
        b      = '0;
        b.cond = 4'hE;
        return b;
    endfunction

    // Arithmetic done on wide integers: carry is bit 32 of the unsigned sum,
    // overflow is a signed result outside the 32-bit range.
    function automatic void alu_model(input instr_t e, output logic [31:0] r,
                                      output logic [3:0] nzcv);
        logic [31:0] b;
        longint unsigned ua, ub, full;
        longint sa, sb, sr, maxs, mins;
        logic c, v;
        b    = e.alusrc ? e.ext : e.rd2;
        ua   = {32'd0, e.rd1};
        ub   = {32'd0, b};
        sa   = longint'($signed(e.rd1));
        sb   = longint'($signed(b));
        maxs = (longint'(1) <<< 31) - 1;
        mins = -(longint'(1) <<< 31);
        c    = 1'b0;
        v    = 1'b0;
        r    = '0;
        case (e.aluc)
            3'd0: begin
                full = ua + ub; r = full[31:0]; c = full[32];
                sr = sa + sb; v = (sr > maxs) || (sr < mins);
            end
            3'd1: begin
                full = ua - ub; r = full[31:0]; c = (ua >= ub);
                sr = sa - sb; v = (sr > maxs) || (sr < mins);
            end
            3'd2: r = e.rd1 & b;
            3'd3: r = e.rd1 | b;
            3'd4: r = e.rd1 ^ b;
            3'd5: r = b;
            3'd6: r = e.rd1 & ~b;
            default: r = ~b;
        endcase
        nzcv = {r[31], (r == 32'd0), c, v};
    endfunction

    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v;
        {n, z, c, v} = f;
        case (cond)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return c;
            4'h3: return !c;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return c && !z;
            4'h9: return !c || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Drive one cycle of stimulus and predict the state after the next edge.
    task automatic issue(input stim_t s);
        logic [31:0] r;
        logic [3:0]  f;
        exp_t        x;
        logic        pass;
        cur = s;
        if (!s.rst_n) begin
            m_e     = bubble();
            m_flags = 4'b0000;
        end else begin
            alu_model(m_e, r, f);
            if (!s.stall && cond_pass(m_e.cond, m_flags)) begin
                if (m_e.fw[1]) m_flags[3:2] = f[3:2];
                if (m_e.fw[0]) m_flags[1:0] = f[1:0];
            end
            if (s.flush)       m_e = bubble();
            else if (!s.stall) m_e = s.d;
        end
        alu_model(m_e, r, f);
        pass       = cond_pass(m_e.cond, m_flags);
        x.condex   = pass;
        x.pcsrc    = m_e.pcsrc & pass;
        x.regwrite = m_e.regwrite & pass;
        x.memwrite = m_e.memwrite & pass;
        x.memtoreg = m_e.memtoreg;
        x.rd       = m_e.rd;
        x.res      = r;
        x.wd       = m_e.rd2;
        x.flags    = m_flags;
        sb_q.push_back(x);
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'hFFFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s.rst_n      = ($urandom_range(0, 59) != 0);
        s.stall      = ($urandom_range(0, 4) == 0);
        s.flush      = ($urandom_range(0, 7) == 0);
        s.d.pcsrc    = 1'($urandom_range(0, 1));
        s.d.regwrite = 1'($urandom_range(0, 1));
        s.d.memtoreg = 1'($urandom_range(0, 1));
        s.d.memwrite = 1'($urandom_range(0, 1));
        s.d.alusrc   = 1'($urandom_range(0, 1));
        s.d.fw       = 2'($urandom_range(0, 3));
        s.d.aluc     = 3'($urandom_range(0, 7));
        s.d.cond     = 4'($urandom_range(0, 15));
        s.d.rd       = 4'($urandom_range(0, 15));
        s.d.rd1      = pick_val();
        s.d.rd2      = pick_val();
        s.d.ext      = pick_val();
        return s;
    endfunction

    // Plain always-executed instruction, no side effects, no stall/flush.
    function automatic stim_t op(input logic [2:0] aluc, input logic [31:0] a,
                                 input logic [31:0] b, input logic [1:0] fw,
                                 input logic [3:0] cond);
        stim_t s;
        s        = '0;
        s.rst_n  = 1'b1;
        s.d.aluc = aluc;
        s.d.rd1  = a;
        s.d.rd2  = b;
        s.d.fw   = fw;
        s.d.cond = cond;
        s.d.rd   = 4'd3;
        return s;
    endfunction

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() != 0) begin
                x = sb_q.pop_front();
                check("PCSrcE",     {31'd0, PCSrcE},    {31'd0, x.pcsrc});
                check("RegWriteE",  {31'd0, RegWriteE}, {31'd0, x.regwrite});
                check("MemWriteE",  {31'd0, MemWriteE}, {31'd0, x.memwrite});
                check("MemtoRegE",  {31'd0, MemtoRegE}, {31'd0, x.memtoreg});
                check("CondExE",    {31'd0, CondExE},   {31'd0, x.condex});
                check("RdE",        {28'd0, RdE},       {28'd0, x.rd});
                check("ALUResultE", ALUResultE,         x.res);
                check("WriteDataE", WriteDataE,         x.wd);
                check("FlagsE",     {28'd0, FlagsE},    {28'd0, x.flags});
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        stim_t s;
        m_e     = bubble();
        m_flags = 4'b0000;

        // Reset held low for two cycles with random decode inputs.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            s = rand_stim(); s.rst_n = 1'b0;
            issue(s);
        end

        // SUB 5-5 sets Z,C; ADDEQ then writes, ADDNE does not.
        @(negedge clk); issue(op(3'd1, 32'd5, 32'd5, 2'b11, 4'hE));
        @(negedge clk); s = op(3'd0, 32'd1, 32'd2, 2'b00, 4'h0); s.d.regwrite = 1'b1; issue(s);
        @(negedge clk); s = op(3'd0, 32'd1, 32'd2, 2'b00, 4'h1); s.d.regwrite = 1'b1; issue(s);

        // Signed overflow sets N,V; GE passes, LT fails.
        @(negedge clk); issue(op(3'd0, 32'h7FFF_FFFF, 32'd1, 2'b11, 4'hE));
        @(negedge clk); s = op(3'd2, 32'hF0, 32'h3C, 2'b00, 4'hA); s.d.regwrite = 1'b1; issue(s);
        @(negedge clk); s = op(3'd2, 32'hF0, 32'h3C, 2'b00, 4'hB); s.d.regwrite = 1'b1; issue(s);

        // Flag-setting SUB held in E for three stalled cycles.
        @(negedge clk); issue(op(3'd1, 32'd3, 32'd7, 2'b11, 4'hE));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); s = rand_stim(); s.rst_n = 1'b1; s.stall = 1'b1; s.flush = 1'b0;
            issue(s);
        end
        @(negedge clk); issue(op(3'd3, 32'h1, 32'h2, 2'b00, 4'hE));

        // Flush drops a store; flush with stall still yields a bubble.
        @(negedge clk); s = op(3'd0, 32'd9, 32'd9, 2'b00, 4'hE); s.d.memwrite = 1'b1;
        s.d.rd = 4'd7; s.flush = 1'b1; issue(s);
        @(negedge clk); s = op(3'd0, 32'd9, 32'd9, 2'b11, 4'hE); s.d.memwrite = 1'b1; issue(s);
        @(negedge clk); s = op(3'd4, 32'd1, 32'd1, 2'b00, 4'hE); s.stall = 1'b1; s.flush = 1'b1;
        issue(s);

        // Never-condition branch, then MVN of a zero immediate.
        @(negedge clk); s = op(3'd0, 32'd1, 32'd1, 2'b00, 4'hF); s.d.pcsrc = 1'b1; issue(s);
        @(negedge clk); s = op(3'd7, 32'd5, 32'd6, 2'b00, 4'hE); s.d.alusrc = 1'b1;
        s.d.ext = 32'd0; issue(s);

        // Randomized traffic, including mid-stream resets, stalls and flushes.
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            issue(rand_stim());
        end

        @(negedge clk); issue(op(3'd0, 32'd0, 32'd0, 2'b00, 4'hE));
        repeat (2) @(posedge clk);
        #2;
        check("scoreboard_drained", sb_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
